// File: rtl/fc_axil_regs.sv
// AXI4-Lite slave with four 32-bit control registers for the Fully_Connected_1 core.
// Write address and data are accepted independently; a commit pulses wr_pulse for the target register.
module fc_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
    output logic [3:0]                        wr_pulse
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    logic          aw_hold_q, aw_hold_d;
    logic [1:0]    aw_idx_q, aw_idx_d;
    logic          w_hold_q, w_hold_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [NB-1:0] w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic [3:0]    wr_pulse_q, wr_pulse_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [1:0]    wr_idx, rd_idx;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_strb;
    logic [3:0][DW-1:0] slv_reg_vec;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = ARESETN & ~aw_hold_q & ~bvalid_q;
    assign S_AXI_WREADY  = ARESETN & ~w_hold_q & ~bvalid_q;
    assign S_AXI_ARREADY = ARESETN & ~rvalid_q;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Commit as soon as both halves are present, whether held or arriving this cycle.
    assign commit  = (aw_hold_q | aw_hs) & (w_hold_q | w_hs);
    assign wr_idx  = aw_hold_q ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_hold_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_hold_q ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[3:2];

    always_comb begin
        aw_hold_d  = aw_hold_q;
        aw_idx_d   = aw_idx_q;
        w_hold_d   = w_hold_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        wr_pulse_d = '0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;

        if (commit) begin
            aw_hold_d = 1'b0;
            w_hold_d  = 1'b0;
            bvalid_d  = 1'b1;
            wr_pulse_d[wr_idx] = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_hold_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_hold_d = 1'b1;
                w_data_d = S_AXI_WDATA;
                w_strb_d = S_AXI_WSTRB;
            end
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end
        end

        // Reads sample the registered value, so a same-edge commit is not visible yet.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = slv_reg_vec[rd_idx];
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_hold_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_hold_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            aw_hold_q  <= aw_hold_d;
            aw_idx_q   <= aw_idx_d;
            w_hold_q   <= w_hold_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        logic [DW-1:0] reg_d, reg_q;

        always_comb begin
            reg_d = reg_q;
            if (commit && wr_idx == 2'(gi)) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_strb[b]) begin
                        reg_d[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end

        always_ff @(posedge ACLK) begin
            if (!ARESETN) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign slv_reg_vec[gi] = reg_q;
    end

    assign slv_reg0     = slv_reg_vec[0];
    assign slv_reg1     = slv_reg_vec[1];
    assign slv_reg2     = slv_reg_vec[2];
    assign slv_reg3     = slv_reg_vec[3];
    assign wr_pulse     = wr_pulse_q;
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = 2'b00;

endmodule

// File: tb/tb_fc_axil_regs.sv
// Bench for fc_axil_regs: table of write/read vectors with a read-data scoreboard,
// plus hand-written sequences for split writes, back-pressure, collisions and reset.
module tb_fc_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic [3:0]  wr_pulse;

    fc_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3),
        .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;   // expected wr_pulse for writes, RDATA for reads
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Called at a negedge; returns at the negedge after BVALID has been consumed.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [3:0] exp_pulse);
        int  t;
        logic aw_ok, w_ok;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        t = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && t < 20) begin
            aw_ok = S_AXI_AWREADY;
            w_ok  = S_AXI_WREADY;
            @(negedge ACLK);
            if (aw_ok) S_AXI_AWVALID = 1'b0;
            if (w_ok)  S_AXI_WVALID  = 1'b0;
            t++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        t = 0;
        while (!S_AXI_BVALID && t < 10) begin @(negedge ACLK); t++; end
        if (!S_AXI_BVALID) timeout("write_bvalid");
        else begin
            chk("wr_pulse", {28'h0, wr_pulse}, {28'h0, exp_pulse});
            chk("bresp", {30'h0, S_AXI_BRESP}, 32'h0);
        end
        $display("write addr=%h data=%h strb=%b pulse=%b", a, d, s, wr_pulse);
        @(negedge ACLK);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] e);
        int t;
        logic [31:0] exp;
        sb_q.push_back(e);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        t = 0;
        while (!S_AXI_ARREADY && t < 20) begin @(negedge ACLK); t++; end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        t = 0;
        while (!S_AXI_RVALID && t < 10) begin @(negedge ACLK); t++; end
        exp = sb_q.pop_front();
        if (!S_AXI_RVALID) timeout("read_rvalid");
        else begin
            chk("rdata", S_AXI_RDATA, exp);
            chk("rresp", {30'h0, S_AXI_RRESP}, 32'h0);
        end
        $display("read  addr=%h data=%h", a, S_AXI_RDATA);
        @(negedge ACLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h1};
        tbl[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h2};
        tbl[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h4};
        tbl[3]  = '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h8};
        tbl[4]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h1};
        tbl[5]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h2};
        tbl[6]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h3};
        tbl[7]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h4};
        tbl[8]  = '{1'b1, 4'h4, 32'h1122_3344, 4'hF, 32'h2};
        tbl[9]  = '{1'b1, 4'h5, 32'hAABB_CCDD, 4'h5, 32'h2};
        tbl[10] = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h11BB_33DD};
        tbl[11] = '{1'b0, 4'h7, 32'h0,         4'h0, 32'h11BB_33DD};
        tbl[12] = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h2};
        tbl[13] = '{1'b1, 4'h8, 32'h0000_0003, 4'h0, 32'h4};
        tbl[14] = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h3};

        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        repeat (2) @(negedge ACLK);
        chk("rst_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
        chk("rst_wready",  {31'h0, S_AXI_WREADY},  32'h0);
        chk("rst_arready", {31'h0, S_AXI_ARREADY}, 32'h0);
        chk("rst_bvalid",  {31'h0, S_AXI_BVALID},  32'h0);
        chk("rst_rvalid",  {31'h0, S_AXI_RVALID},  32'h0);
        chk("rst_rdata",   S_AXI_RDATA, 32'h0);
        chk("rst_pulse",   {28'h0, wr_pulse}, 32'h0);
        chk("rst_regs",    slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 32'h0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("idle_awready", {31'h0, S_AXI_AWREADY}, 32'h1);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp[3:0]);
            else           do_read(tbl[i].addr, tbl[i].exp);
        end

        // W three cycles ahead of AW.
        S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        chk("split_wready_low", {31'h0, S_AXI_WREADY}, 32'h0);
        repeat (2) @(negedge ACLK);
        chk("split_wready_held", {31'h0, S_AXI_WREADY}, 32'h0);
        chk("split_no_bvalid",   {31'h0, S_AXI_BVALID}, 32'h0);
        chk("split_reg2_old",    slv_reg2, 32'h3);
        S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
        chk("split_awready", {31'h0, S_AXI_AWREADY}, 32'h1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        chk("split_bvalid", {31'h0, S_AXI_BVALID}, 32'h1);
        chk("split_reg2",   slv_reg2, 32'hDEAD_BEEF);
        chk("split_pulse",  {28'h0, wr_pulse}, 32'h4);
        $display("write addr=8 data=deadbeef (W before AW)");
        @(negedge ACLK);
        chk("split_bvalid_clr", {31'h0, S_AXI_BVALID}, 32'h0);

        // BREADY held low.
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid",  {31'h0, S_AXI_BVALID},  32'h1);
            chk("bp_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
            chk("bp_wready",  {31'h0, S_AXI_WREADY},  32'h0);
            chk("bp_pulse",   {28'h0, wr_pulse}, (i == 0) ? 32'h8 : 32'h0);
            @(negedge ACLK);
        end
        chk("bp_reg3", slv_reg3, 32'h77);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        chk("bp_bvalid_clr", {31'h0, S_AXI_BVALID}, 32'h0);
        $display("write addr=c data=00000077 (BREADY stalled 5 cycles)");

        // RREADY held low.
        S_AXI_RREADY = 1'b0;
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
        sb_q.push_back(32'h1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk("rp_first", S_AXI_RDATA, sb_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            chk("rp_rvalid",  {31'h0, S_AXI_RVALID},  32'h1);
            chk("rp_rdata",   S_AXI_RDATA, 32'h1);
            chk("rp_arready", {31'h0, S_AXI_ARREADY}, 32'h0);
            @(negedge ACLK);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        chk("rp_rvalid_clr", {31'h0, S_AXI_RVALID}, 32'h0);
        $display("read  addr=0 data=00000001 (RREADY stalled 5 cycles)");

        // Read and commit to register 1 on the same edge.
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
        sb_q.push_back(32'h2);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("col_rvalid", {31'h0, S_AXI_RVALID}, 32'h1);
        chk("col_rdata",  S_AXI_RDATA, sb_q.pop_front());
        chk("col_reg1",   slv_reg1, 32'h55);
        chk("col_pulse",  {28'h0, wr_pulse}, 32'h2);
        $display("write addr=4 data=00000055 with same-edge read data=%h", S_AXI_RDATA);
        @(negedge ACLK);
        do_read(4'h4, 32'h55);

        // Reset while BVALID is pending.
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("rst2_bvalid_pend", {31'h0, S_AXI_BVALID}, 32'h1);
        ARESETN = 1'b0;
        #1;
        chk("rst2_readies", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
        @(negedge ACLK);
        chk("rst2_bvalid", {31'h0, S_AXI_BVALID}, 32'h0);
        chk("rst2_regs",   slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 32'h0);
        chk("rst2_rdata",  S_AXI_RDATA, 32'h0);
        chk("rst2_pulse",  {28'h0, wr_pulse}, 32'h0);
        $display("reset during pending write response");
        ARESETN = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        do_read(4'h0, 32'h0);

        chk("sb_empty", sb_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
